div_32_bit: RTL and testbench
=============================

DIV_32_BIT -- requirements
Module: div_32_bit

Interface
REQ-001 Parameter WIDTH, default 32: operand, quotient and remainder width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clr_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 a  input  WIDTH  signed dividend (two's complement).
REQ-006 b  input  WIDTH  signed divisor (two's complement).
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  one-cycle pulse; results valid.
REQ-009 z  output  2*WIDTH  result: z[2W-1:W] = remainder (HI), z[W-1:0] = quotient (LO).
REQ-010 div_by_zero  output  1  set with done when b was zero.

Function
REQ-011 The FSM SHALL have three states: IDLE, CALC and FIX.
REQ-012 In IDLE with start=1 at a rising edge (edge 0), the block SHALL latch |a| and |b|, latch the result sign flags, clear the partial remainder, set the counter to WIDTH-1, and enter CALC.
REQ-013 Sign flags: quotient is negative iff a[W-1] differs from b[W-1]; remainder takes the sign of a.
REQ-014 Each CALC edge SHALL do one restoring step, MSB-first:
  - shift {rem,quo} left 1;
  - trial = rem - |b| (WIDTH+1 bits);
  - if trial is non-negative, rem = trial and quotient bit = 1; otherwise rem is kept and quotient bit = 0.
REQ-015 After WIDTH CALC edges (edges 1..WIDTH), the state SHALL be FIX.
REQ-016 The FIX edge (edge WIDTH+1) SHALL:
  - negate the magnitudes per the sign flags;
  - register z;
  - assert done for exactly the following cycle;
  - return to IDLE.
REQ-017 busy SHALL be high from after edge 0 through edge WIDTH+1, and SHALL be low whenever done is high.
REQ-018 start while busy SHALL be ignored; latched operands SHALL NOT change mid-operation.
REQ-019 start sampled in the cycle done is high SHALL be accepted as a new operation (back-to-back, no dead cycle).
REQ-020 z and div_by_zero SHALL hold their last values until the next FIX (or zero-detect) edge, and SHALL NOT change during CALC.
REQ-021 a = -2^(W-1), b = -1 SHALL yield quotient 0x80000000 (wrapped), remainder 0, with no flag.
REQ-022 Arithmetic SHALL be truncating division: a = q*b + r, with |r| < |b|.

Reset
REQ-023 On clr_n=0, asynchronously:
  - state = IDLE;
  - busy = 0, done = 0, div_by_zero = 0;
  - z = 0;
  - counter and internal registers cleared.
REQ-024 Reset asserted mid-operation SHALL abort the operation with no done pulse. The first start after clr_n rises SHALL behave exactly as from power-up.

Configuration
REQ-025 Macro DIV_BY_ZERO_DETECT_EN controls divide-by-zero handling.
REQ-026 With DIV_BY_ZERO_DETECT_EN defined, start with b=0 SHALL skip CALC and FIX:
  - the next edge SHALL set quotient = all ones, remainder = a, div_by_zero = 1;
  - done SHALL pulse one cycle after the start edge;
  - div_by_zero SHALL clear at the next accepted start.
REQ-027 Without DIV_BY_ZERO_DETECT_EN:
  - div_by_zero SHALL be tied 0;
  - b=0 SHALL run the normal WIDTH+2 cycle sequence;
  - the result SHALL be the algorithm's natural output: magnitude quotient all ones and remainder |a|, then sign fix per REQ-013.

Verification
REQ-028 a=100, b=7, start at edge 0 -> done high after edge 33; z[31:0]=14, z[63:32]=2; busy low with done.
REQ-029 a=-100 (0xFFFFFF9C), b=7 -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE; a=100, b=-7 -> quotient 0xFFFFFFF2, remainder 2.
REQ-030 a=0x80000000, b=0xFFFFFFFF -> quotient 0x80000000, remainder 0, div_by_zero=0.
REQ-031 b=0, a=55:
  - with DIV_BY_ZERO_DETECT_EN -> done after edge 1; quotient 0xFFFFFFFF, remainder 55, div_by_zero=1;
  - without it -> done after edge 33, div_by_zero=0.
REQ-032 a=100, b=7:
  - second start with a=9, b=3 at edge 10 -> ignored; result 14/2;
  - start with a=9, b=3 in the done cycle -> next done yields 3/0.
REQ-033 clr_n low at edge 15 of an operation -> z=0, busy=0, and no done pulse.
REQ-034 After clr_n rises, a=100, b=7 -> 14/2 with identical timing to REQ-028.

Source files
------------

// File: rtl/div_32_bit.sv
// div_32_bit: signed restoring divider, z = {remainder, quotient}; DIV_BY_ZERO_DETECT_EN short-circuits b == 0
module div_32_bit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   z,
    output logic                 div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t           state;
    logic [WIDTH-1:0] rem, quo, mag_b, abs_a, abs_b;
    logic [CW-1:0]    cnt;
    logic             q_neg, r_neg, dz, dz_out, zero;
    logic [WIDTH:0]   trial;
`ifdef DIV_BY_ZERO_DETECT_EN
    assign zero = b == '0;
`else
    assign zero = 1'b0;
`endif
    assign div_by_zero = dz_out;
    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;
    assign trial = {rem, quo[WIDTH-1]} - {1'b0, mag_b};
    // a zero divisor jumps straight to FIX with quotient all ones and remainder |a|, so FIX restores a
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= IDLE;
            rem    <= '0;
            quo    <= '0;
            mag_b  <= '0;
            cnt    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            dz     <= 1'b0;
            dz_out <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            z      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    rem    <= zero ? abs_a : '0;
                    quo    <= zero ? '1 : abs_a;
                    mag_b  <= abs_b;
                    q_neg  <= zero ? 1'b0 : a[WIDTH-1] ^ b[WIDTH-1];
                    r_neg  <= a[WIDTH-1];
                    cnt    <= LAST;
                    dz     <= zero;
                    dz_out <= 1'b0;
                    busy   <= 1'b1;
                    state  <= zero ? FIX : CALC;
                end
                CALC: begin
                    rem   <= trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
                    quo   <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                    cnt   <= cnt - 1'b1;
                    state <= cnt == '0 ? FIX : CALC;
                end
                FIX: begin
                    z      <= {r_neg ? -rem : rem, q_neg ? -quo : quo};
                    dz_out <= dz;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_32_bit.sv
// tb_div_32_bit: directed vectors for div_32_bit in its default build
module tb_div_32_bit;
    logic        clk, clr_n, start;
    logic [31:0] a, b;
    logic        busy, done, div_by_zero;
    logic [63:0] z;
    int          passed = 0, total = 0;

    div_32_bit dut (
        .clk(clk), .clr_n(clr_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .z(z), .div_by_zero(div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic start_op(input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!done && n < 200);
        if (!done) check("timeout", 64'(n), 64'd0);
    endtask

    task automatic run(input string tag, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] q, input logic [31:0] r, input logic dz, input int lat);
        int n;
        start_op(va, vb);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(n);
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_z"}, z, {r, q});
        check({tag, "_dz"}, 64'(div_by_zero), 64'(dz));
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int n, seen;
        clr_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        #1;
        check("rst_z", z, 64'd0);
        check("rst_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;

        run("pos", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        run("nega", 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33);
        run("negb", 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, 33);
        run("negab", 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 1'b0, 33);
        run("ovf", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 33);
        run("small", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 33);
`ifdef DIV_BY_ZERO_DETECT_EN
        run("bz", 32'd55, 32'd0, 32'hFFFFFFFF, 32'd55, 1'b1, 1);
        run("bz_clr", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
`else
        run("bz", 32'd55, 32'd0, 32'hFFFFFFFF, 32'd55, 1'b0, 33);
`endif

        start_op(32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        a = 32'd9;
        b = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("ign_busy", 64'(busy), 64'd1);
        check("ign_hold_z", z, {32'd55, 32'hFFFFFFFF});
        wait_done(n);
        check("ign_lat", 64'(n), 64'd23);
        check("ign_z", z, {32'd2, 32'd14});

        a = 32'd9;
        b = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b_busy", {62'd0, busy, done}, 64'd2);
        wait_done(n);
        check("b2b_lat", 64'(n), 64'd33);
        check("b2b_z", z, {32'd0, 32'd3});

        start_op(32'd100, 32'd7);
        repeat (14) @(posedge clk);
        #1 clr_n = 1'b0;
        #1;
        check("abort_z", z, 64'd0);
        check("abort_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("abort_quiet", 64'(seen), 64'd0);
        run("after_rst", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
